// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core:
// opcodes, functs, controller states and ALU controls.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_ZERO
    } alu_ctrl_t;

    // Unrecognised functs give a defined zero result rather than a trap
    function automatic alu_ctrl_t funct_ctrl(input logic [5:0] f);
        case (f)
            F_ADD:   return ALU_ADD;
            F_SUB:   return ALU_SUB;
            F_AND:   return ALU_AND;
            F_OR:    return ALU_OR;
            F_SLT:   return ALU_SLT;
            default: return ALU_ZERO;
        endcase
    endfunction

    function automatic logic [31:0] alu(
        input alu_ctrl_t   c,
        input logic [31:0] a,
        input logic [31:0] b
    );
        case (c)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return {31'd0, $signed(a) < $signed(b)};
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_ram.sv
// Unified instruction/data memory: combinational read,
// synchronous write. Contents survive reset.
module mem_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);

    logic [31:0] mem [0:MEM_DEPTH-1];

    assign rd = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wd;
    end

endmodule

// File: rtl/multi_cycle_cpu.sv
// 32-bit MIPS multi-cycle core: shared memory, one ALU,
// two-process FSM controller and debug taps.
module multi_cycle_cpu
    import mips_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] regs_debug [0:31],
    output logic [31:0] pc_debug,
    output logic [31:0] instr_debug
);

    localparam int AW = $clog2(MEM_DEPTH);

    state_t      state, nstate;
    logic [31:0] pc, ir, mdr, a, b, aluout;
    logic [31:0] rf [0:31];

    logic [31:0] src_a, src_b, alu_y, pc_next, wd, mem_rd;
    alu_ctrl_t   alu_op;
    logic [4:0]  wa;
    logic [AW-1:0] mem_idx;
    logic ir_we, ab_we, mdr_we, aluout_we, rf_we, mem_we;
    logic fetch, branch, jump, data_addr, pc_load;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sx;

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign imm_sx = {{16{ir[15]}}, ir[15:0]};

    assign alu_y   = alu(alu_op, src_a, src_b);
    assign mem_idx = data_addr ? aluout[AW+1:2] : pc[AW+1:2];

    mem_ram #(.MEM_DEPTH(MEM_DEPTH)) i_ram (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_idx),
        .wd   (b),
        .rd   (mem_rd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= nstate;
    end

    always_comb begin
        nstate    = S_FETCH;
        src_a     = pc;
        src_b     = 32'd4;
        alu_op    = ALU_ADD;
        wa        = rt;
        wd        = aluout;
        ir_we     = 1'b0;
        ab_we     = 1'b0;
        mdr_we    = 1'b0;
        aluout_we = 1'b0;
        rf_we     = 1'b0;
        mem_we    = 1'b0;
        fetch     = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        data_addr = 1'b0;
        unique case (state)
            S_FETCH: begin
                ir_we  = 1'b1;
                fetch  = 1'b1;
                nstate = S_DECODE;
            end
            S_DECODE: begin
                // PC already holds PC+4, so ALUOut becomes the beq target
                ab_we     = 1'b1;
                aluout_we = 1'b1;
                src_b     = {imm_sx[29:0], 2'b00};
                unique case (1'b1)
                    (op == OP_LW),
                    (op == OP_SW):     nstate = S_MEMADR;
                    (op == OP_RTYPE):  nstate = S_EXECUTE;
                    (op == OP_BEQ):    nstate = S_BRANCH;
                    (op == OP_ADDI):   nstate = S_ADDIEX;
                    (op == OP_J):      nstate = S_JUMP;
                    default:           nstate = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                src_a     = a;
                src_b     = imm_sx;
                aluout_we = 1'b1;
                nstate    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                data_addr = 1'b1;
                mdr_we    = 1'b1;
                nstate    = S_MEMWB;
            end
            S_MEMWB: begin
                rf_we = 1'b1;
                wd    = mdr;
            end
            S_MEMWR: begin
                data_addr = 1'b1;
                mem_we    = 1'b1;
            end
            S_EXECUTE: begin
                src_a     = a;
                src_b     = b;
                alu_op    = funct_ctrl(funct);
                aluout_we = 1'b1;
                nstate    = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we = 1'b1;
                wa    = rd;
            end
            S_BRANCH: begin
                src_a  = a;
                src_b  = b;
                alu_op = ALU_SUB;
                branch = 1'b1;
            end
            S_ADDIEX: begin
                src_a     = a;
                src_b     = imm_sx;
                aluout_we = 1'b1;
                nstate    = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we = 1'b1;
            end
            S_JUMP: begin
                jump = 1'b1;
            end
            default: nstate = S_FETCH;
        endcase
    end

    always_comb begin
        pc_next = alu_y;
        if (jump)        pc_next = {pc[31:28], ir[25:0], 2'b00};
        else if (branch) pc_next = aluout;
    end

    assign pc_load = fetch | jump | (branch & (alu_y == 32'd0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= '0;
            ir     <= '0;
            mdr    <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if (pc_load)   pc     <= pc_next;
            if (ir_we)     ir     <= mem_rd;
            if (mdr_we)    mdr    <= mem_rd;
            if (aluout_we) aluout <= alu_y;
            if (ab_we) begin
                a <= rf[rs];
                b <= rf[rt];
            end
            if (rf_we && wa != 5'd0) rf[wa] <= wd;
        end
    end

    assign regs_debug  = rf;
    assign pc_debug    = pc;
    assign instr_debug = ir;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Bench for multi_cycle_cpu: directed programs plus random
// programs checked against an instruction-level model.
module tb_multi_cycle_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] regs_debug [0:31];
    logic [31:0] pc_debug;
    logic [31:0] instr_debug;

    multi_cycle_cpu #(.MEM_DEPTH(256)) dut (
        .clk         (clk),
        .reset       (reset),
        .regs_debug  (regs_debug),
        .pc_debug    (pc_debug),
        .instr_debug (instr_debug)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] prog [0:255];
    logic [31:0] mm   [0:255];
    logic [31:0] mr   [0:31];
    logic [31:0] mpc;
    logic [31:0] mir;
    int          mcyc;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 32'd0;
    endtask

    // Loads prog into the DUT and the model while reset is held
    task automatic boot(input bit chk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            dut.i_ram.mem[i] <= prog[i];
            mm[i] = prog[i];
        end
        for (int i = 0; i < 32; i++) mr[i] = 32'd0;
        mpc  = 32'd0;
        mir  = 32'd0;
        mcyc = 0;
        @(negedge clk);
        @(negedge clk);
        if (chk) begin
            check("reset_pc", pc_debug, 32'd0);
            check("reset_ir", instr_debug, 32'd0);
            for (int i = 0; i < 32; i++)
                check($sformatf("reset_r%0d", i), regs_debug[i], 32'd0);
        end
        reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wreg(input logic [4:0] n, input logic [31:0] v);
        if (n != 5'd0) mr[n] = v;
    endtask

    // One instruction at ISA level; cycle cost from the CPI table
    task automatic m_step();
        logic [31:0] ins, a, b, s, ea, r;
        ins  = mm[mpc[9:2]];
        mir  = ins;
        mpc  = mpc + 32'd4;
        a    = mr[ins[25:21]];
        b    = mr[ins[20:16]];
        s    = {{16{ins[15]}}, ins[15:0]};
        ea   = a + s;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20:   r = a + b;
                    6'h22:   r = a - b;
                    6'h24:   r = a & b;
                    6'h25:   r = a | b;
                    6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: r = 32'd0;
                endcase
                wreg(ins[15:11], r);
                mcyc += 4;
            end
            6'h08: begin wreg(ins[20:16], ea); mcyc += 4; end
            6'h23: begin wreg(ins[20:16], mm[ea[9:2]]); mcyc += 5; end
            6'h2B: begin mm[ea[9:2]] = b; mcyc += 4; end
            6'h04: begin
                if (a == b) mpc = mpc + {s[29:0], 2'b00};
                mcyc += 3;
            end
            6'h02: begin
                mpc = {mpc[31:28], ins[25:0], 2'b00};
                mcyc += 3;
            end
            default: mcyc += 2;
        endcase
    endtask

    function automatic logic [5:0] rand_funct();
        case ($urandom_range(0, 5))
            0:       return 6'h20;
            1:       return 6'h22;
            2:       return 6'h24;
            3:       return 6'h25;
            4:       return 6'h2A;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs, rt, rd;
        int off;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0, 1, 2: return enc_i(6'h08, rs, rt, 16'($urandom));
            3, 4:    return enc_r(rs, rt, rd, rand_funct());
            5: return enc_i(6'h23, 5'd0, rt,
                            16'(512 + 4 * $urandom_range(0, 63)));
            6: return enc_i(6'h2B, 5'd0, rt,
                            16'(512 + 4 * $urandom_range(0, 63)));
            7: begin
                off = int'($urandom_range(0, 8)) - 3;
                return enc_i(6'h04, rs, rt, 16'(off));
            end
            8:       return enc_j(26'($urandom_range(0, 47)));
            default: return {6'h3F, 26'($urandom)};
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state and first fetch; beq taken
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
        prog[1] = enc_i(6'h08, 5'd0, 5'd9, 16'd5);
        prog[2] = enc_i(6'h04, 5'd8, 5'd9, 16'd1);
        prog[3] = enc_i(6'h08, 5'd0, 5'd19, 16'd1);
        prog[4] = enc_i(6'h08, 5'd0, 5'd16, 16'd42);
        boot(1'b1);
        run(1);
        check("fetch_pc", pc_debug, 32'd4);
        check("fetch_ir", instr_debug, prog[0]);
        run(14);
        check("beq_t_s0", regs_debug[16], 32'h2A);
        check("beq_t_s3", regs_debug[19], 32'd0);
        check("beq_t_pc", pc_debug, 32'h14);

        // asynchronous reset mid-instruction, then clean restart
        boot(1'b0);
        run(6);
        check("pre_rst_t0", regs_debug[8], 32'd5);
        #2;
        reset = 1'b0;
        #1;
        check("arst_pc", pc_debug, 32'd0);
        check("arst_ir", instr_debug, 32'd0);
        check("arst_t0", regs_debug[8], 32'd0);
        check("arst_mem", dut.i_ram.mem[4], prog[4]);
        @(negedge clk);
        reset = 1'b1;
        run(15);
        check("rerun_s0", regs_debug[16], 32'h2A);

        // beq not taken
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
        prog[1] = enc_i(6'h08, 5'd0, 5'd9, 16'd6);
        prog[2] = enc_i(6'h04, 5'd8, 5'd9, 16'd1);
        prog[3] = enc_i(6'h08, 5'd0, 5'd17, 16'd88);
        boot(1'b0);
        run(15);
        check("beq_nt_s1", regs_debug[17], 32'h58);
        check("beq_nt_pc", pc_debug, 32'h10);

        // j with upper address bits ignored by memory
        clear_prog();
        prog[0]  = enc_j(26'h010000C);
        prog[1]  = enc_i(6'h08, 5'd0, 5'd19, 16'd1);
        prog[12] = enc_i(6'h08, 5'd0, 5'd18, 16'd77);
        boot(1'b0);
        run(3);
        check("j_pc", pc_debug, 32'h00400030);
        run(4);
        check("j_s2", regs_debug[18], 32'h4D);
        check("j_s3", regs_debug[19], 32'd0);
        check("j_pc2", pc_debug, 32'h00400034);

        // sw then lw, lw needs its fifth cycle
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd8, 16'h40);
        prog[1] = enc_i(6'h2B, 5'd8, 5'd8, 16'd0);
        prog[2] = enc_i(6'h23, 5'd8, 5'd10, 16'd0);
        boot(1'b0);
        run(8);
        check("sw_mem16", dut.i_ram.mem[16], 32'h40);
        run(4);
        check("lw_cyc4_t2", regs_debug[10], 32'd0);
        run(1);
        check("lw_t2", regs_debug[10], 32'h40);
        check("lw_pc", pc_debug, 32'hC);

        // R-type on 7 and -3, write to $0 discarded
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd7);
        prog[1] = enc_i(6'h08, 5'd0, 5'd9, 16'hFFFD);
        prog[2] = enc_r(5'd8, 5'd9, 5'd16, 6'h22);
        prog[3] = enc_r(5'd8, 5'd9, 5'd17, 6'h24);
        prog[4] = enc_r(5'd8, 5'd9, 5'd18, 6'h25);
        prog[5] = enc_r(5'd8, 5'd9, 5'd19, 6'h2A);
        prog[6] = enc_r(5'd9, 5'd8, 5'd20, 6'h2A);
        prog[7] = enc_r(5'd8, 5'd9, 5'd0, 6'h20);
        boot(1'b0);
        run(32);
        check("r_sub", regs_debug[16], 32'd10);
        check("r_and", regs_debug[17], 32'd5);
        check("r_or", regs_debug[18], 32'hFFFFFFFF);
        check("r_slt0", regs_debug[19], 32'd0);
        check("r_slt1", regs_debug[20], 32'd1);
        check("r_zero", regs_debug[0], 32'd0);

        // random programs against the instruction-level model
        for (int t = 0; t < 20; t++) begin
            clear_prog();
            for (int w = 0; w < 48; w++) prog[w] = rand_instr();
            for (int w = 128; w < 192; w++) prog[w] = $urandom;
            boot(1'b0);
            for (int k = 0; k < 60; k++) m_step();
            run(mcyc);
            for (int i = 0; i < 8; i++)
                check($sformatf("rnd%0d_r%0d", t, i), regs_debug[i], mr[i]);
            check($sformatf("rnd%0d_pc", t), pc_debug, mpc);
            check($sformatf("rnd%0d_ir", t), instr_debug, mir);
            for (int w = 128; w < 192; w++)
                check($sformatf("rnd%0d_m%0d", t, w),
                      dut.i_ram.mem[w], mm[w]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
